// File: rtl/thread_req_queue.sv
// Dispatcher-side receiver for thread fork/stop requests on the inter-CPU message bus.
// Each request is stored in a small fall-through FIFO and answered with a DONE burst.
module thread_req_queue #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 4,
   parameter int ACK_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 cpu_msg_in,
   input  logic [ADDR_W-1:0]          addr_in,
   input  logic [DATA_W-1:0]          data_in,
   output logic [7:0]                 cpu_msg_out,
   output logic                       cpu_msg_oe,
   output logic                       req_valid,
   input  logic                       req_ready,
   output logic                       req_stop,
   output logic [ADDR_W-1:0]          req_addr,
   output logic [DATA_W-1:0]          req_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       busy
);

   localparam logic [7:0] CPU_R_FORK_THRD = 8'h21;
   localparam logic [7:0] CPU_R_FORK_DONE = 8'h22;
   localparam logic [7:0] CPU_R_STOP_THRD = 8'h23;
   localparam logic [7:0] CPU_R_STOP_DONE = 8'h24;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 1 + ADDR_W + DATA_W;
   localparam int ACK_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PEND = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;

   logic [1:0]       state;
   logic [7:0]       msg_prev;
   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic [ENT_W-1:0] hold;
   logic [ACK_W-1:0] ack_cnt;

   logic             is_req;
   logic             req_det;
   logic             pop;
   logic             slot_free;
   logic             push;
   logic [ENT_W-1:0] new_entry;
   logic [ENT_W-1:0] push_entry;
   logic [ENT_W-1:0] head;

   // A held request code counts once: only a change onto a request code is a new request.
   always_comb begin
      is_req     = (cpu_msg_in == CPU_R_FORK_THRD) || (cpu_msg_in == CPU_R_STOP_THRD);
      req_det    = is_req && (cpu_msg_in != msg_prev);
      pop        = req_valid && req_ready;
      slot_free  = (count_q < CNT_W'(DEPTH)) || pop;
      new_entry  = {(cpu_msg_in == CPU_R_STOP_THRD), addr_in, data_in};
      push       = 1'b0;
      push_entry = hold;
      case (state)
         IDLE: begin
            if (req_det && slot_free) begin
               push       = 1'b1;
               push_entry = new_entry;
            end
         end
         PEND: begin
            if (slot_free) begin
               push = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign head      = mem[rd_ptr];
   assign req_valid = (count_q != '0);
   assign req_stop  = req_valid & head[ENT_W-1];
   assign req_addr  = req_valid ? head[ENT_W-2 -: ADDR_W] : '0;
   assign req_data  = req_valid ? head[DATA_W-1:0] : '0;
   assign count     = count_q;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         msg_prev    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         hold        <= '0;
         ack_cnt     <= '0;
         cpu_msg_out <= '0;
         cpu_msg_oe  <= 1'b0;
      end else begin
         msg_prev <= cpu_msg_in;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase

         // The DONE burst starts on the cycle right after the entry is written.
         if (push) begin
            state       <= ACK;
            cpu_msg_oe  <= 1'b1;
            cpu_msg_out <= push_entry[ENT_W-1] ? CPU_R_STOP_DONE : CPU_R_FORK_DONE;
            ack_cnt     <= ACK_W'(ACK_CYCLES - 1);
         end else begin
            case (state)
               IDLE: begin
                  if (req_det) begin
                     hold  <= new_entry;
                     state <= PEND;
                  end
               end
               ACK: begin
                  if (ack_cnt == '0) begin
                     state       <= IDLE;
                     cpu_msg_oe  <= 1'b0;
                     cpu_msg_out <= '0;
                  end else begin
                     ack_cnt <= ack_cnt - 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_thread_req_queue.sv
// Self-checking bench for thread_req_queue: directed scenarios then random traffic,
// all compared every cycle against a queue-based transaction model.
module tb_thread_req_queue;

   localparam int DEPTH      = 4;
   localparam int ACK_CYCLES = 2;

   localparam logic [7:0] FORK_THRD = 8'h21;
   localparam logic [7:0] FORK_DONE = 8'h22;
   localparam logic [7:0] STOP_THRD = 8'h23;
   localparam logic [7:0] STOP_DONE = 8'h24;

   typedef struct packed {
      logic        stop;
      logic [31:0] addr;
      logic [31:0] data;
   } entry_t;

   logic        clk;
   logic        rst;
   logic [7:0]  cpu_msg_in;
   logic [31:0] addr_in;
   logic [31:0] data_in;
   logic [7:0]  cpu_msg_out;
   logic        cpu_msg_oe;
   logic        req_valid;
   logic        req_ready;
   logic        req_stop;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [2:0]  count;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   entry_t     mq[$];
   entry_t     hold_m;
   bit         pend_m;
   int         ack_left;
   logic [7:0] ack_code_m;
   logic [7:0] prev_m;

   thread_req_queue #(
      .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .ACK_CYCLES(ACK_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .cpu_msg_in(cpu_msg_in), .addr_in(addr_in), .data_in(data_in),
      .cpu_msg_out(cpu_msg_out), .cpu_msg_oe(cpu_msg_oe), .req_valid(req_valid),
      .req_ready(req_ready), .req_stop(req_stop), .req_addr(req_addr), .req_data(req_data),
      .count(count), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mq.delete();
      hold_m     = '0;
      pend_m     = 0;
      ack_left   = 0;
      ack_code_m = '0;
      prev_m     = '0;
   endtask

   // One clock edge of the protocol, from the rules rather than from the RTL structure.
   task automatic modelEdge();
      bit     pop, free, det, push;
      entry_t e;
      pop  = (mq.size() > 0) && req_ready;
      free = (mq.size() < DEPTH) || pop;
      det  = ((cpu_msg_in == FORK_THRD) || (cpu_msg_in == STOP_THRD)) && (cpu_msg_in != prev_m);
      push = 0;
      e    = '{stop: (cpu_msg_in == STOP_THRD), addr: addr_in, data: data_in};
      if (ack_left > 0) begin
         ack_left--;
      end else if (pend_m) begin
         if (free) begin
            push   = 1;
            e      = hold_m;
            pend_m = 0;
         end
      end else if (det) begin
         if (free) begin
            push = 1;
         end else begin
            pend_m = 1;
            hold_m = e;
         end
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
         mq.push_back(e);
         ack_left   = ACK_CYCLES;
         ack_code_m = e.stop ? STOP_DONE : FORK_DONE;
      end
      prev_m = cpu_msg_in;
   endtask

   task automatic compareAll();
      entry_t h;
      h = (mq.size() > 0) ? mq[0] : '0;
      checkOutput("oe",    64'(cpu_msg_oe),  64'(ack_left > 0));
      checkOutput("out",   64'(cpu_msg_out), 64'((ack_left > 0) ? ack_code_m : 8'h00));
      checkOutput("count", 64'(count),       64'(mq.size()));
      checkOutput("valid", 64'(req_valid),   64'(mq.size() > 0));
      checkOutput("stop",  64'(req_stop),    64'(h.stop));
      checkOutput("addr",  64'(req_addr),    64'(h.addr));
      checkOutput("data",  64'(req_data),    64'(h.data));
      checkOutput("busy",  64'(busy),        64'(pend_m || (ack_left > 0)));
   endtask

   task automatic applyStimulus(input logic [7:0] msg, input logic [31:0] a, input logic [31:0] d, input logic rdy);
      cpu_msg_in = msg;
      addr_in    = a;
      data_in    = d;
      req_ready  = rdy;
      @(posedge clk);
      modelEdge();
      #1;
      compareAll();
   endtask

   task automatic idleCycles(input int n, input logic rdy);
      for (int i = 0; i < n; i++) applyStimulus(8'h00, 32'h0, 32'h0, rdy);
   endtask

   int done_cycles;

   initial begin
      rst        = 1'b1;
      cpu_msg_in = '0;
      addr_in    = '0;
      data_in    = '0;
      req_ready  = 1'b0;
      modelReset();
      #12;
      compareAll();
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single fork request
      applyStimulus(FORK_THRD, 32'h0000_0100, 32'h0000_2000, 1'b0);
      checkOutput("t1_valid", 64'(req_valid), 64'd1);
      checkOutput("t1_addr",  64'(req_addr),  64'h100);
      checkOutput("t1_data",  64'(req_data),  64'h2000);
      checkOutput("t1_done",  64'(cpu_msg_out), 64'(FORK_DONE));
      idleCycles(1, 1'b0);
      checkOutput("t1_oe2", 64'(cpu_msg_oe), 64'd1);
      idleCycles(1, 1'b0);
      checkOutput("t1_oe_off", 64'(cpu_msg_oe), 64'd0);

      // Stop held five cycles counts once
      done_cycles = 0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(STOP_THRD, 32'h80, 32'h0, 1'b0);
         if (cpu_msg_oe) done_cycles++;
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(8'h00, 32'h0, 32'h0, 1'b0);
         if (cpu_msg_oe) done_cycles++;
      end
      checkOutput("t2_count", 64'(count), 64'd2);
      checkOutput("t2_done_cycles", 64'(done_cycles), 64'(ACK_CYCLES));

      // Drain, then fill past full with the scheduler stalled
      idleCycles(3, 1'b1);
      checkOutput("drain_count", 64'(count), 64'd0);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(FORK_THRD, 32'(i * 16), 32'(i), 1'b0);
         idleCycles(3, 1'b0);
      end
      checkOutput("t3_count", 64'(count), 64'd4);
      checkOutput("t3_busy",  64'(busy), 64'd1);
      checkOutput("t3_no_done", 64'(cpu_msg_oe), 64'd0);
      applyStimulus(8'h00, 32'h0, 32'h0, 1'b1);
      checkOutput("t3_count_after_pop", 64'(count), 64'd4);
      checkOutput("t3_head", 64'(req_addr), 64'h20);
      checkOutput("t3_done", 64'(cpu_msg_out), 64'(FORK_DONE));
      idleCycles(3, 1'b0);

      // Full queue: pop and new request in the same cycle
      applyStimulus(STOP_THRD, 32'h0000_0aaa, 32'h0000_0bbb, 1'b1);
      checkOutput("t4_count", 64'(count), 64'd4);
      checkOutput("t4_done",  64'(cpu_msg_out), 64'(STOP_DONE));
      checkOutput("t4_head",  64'(req_addr), 64'h30);

      // Asynchronous reset on the first DONE cycle
      rst = 1'b1;
      #1;
      modelReset();
      checkOutput("t5_oe",    64'(cpu_msg_oe), 64'd0);
      checkOutput("t5_count", 64'(count), 64'd0);
      checkOutput("t5_valid", 64'(req_valid), 64'd0);
      cpu_msg_in = 8'h00;
      #2;
      rst = 1'b0;
      idleCycles(4, 1'b0);

      // Non-request codes and a request during ACK
      applyStimulus(8'h00, 32'h1, 32'h1, 1'b0);
      applyStimulus(8'h5a, 32'h2, 32'h2, 1'b0);
      applyStimulus(FORK_DONE, 32'h3, 32'h3, 1'b0);
      checkOutput("t6_count_noreq", 64'(count), 64'd0);
      applyStimulus(FORK_THRD, 32'h44, 32'h0, 1'b0);
      applyStimulus(8'h00, 32'h0, 32'h0, 1'b0);
      applyStimulus(STOP_THRD, 32'h55, 32'h0, 1'b0);
      idleCycles(3, 1'b0);
      checkOutput("t6_count_ack", 64'(count), 64'd1);
      checkOutput("t6_head", 64'(req_addr), 64'h44);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] m;
         case ($urandom_range(0, 5))
            0, 1: m = FORK_THRD;
            2:    m = STOP_THRD;
            3:    m = 8'h00;
            4:    m = ($urandom_range(0, 1) != 0) ? FORK_DONE : STOP_DONE;
            default: m = 8'($urandom);
         endcase
         applyStimulus(m, $urandom, $urandom, ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
